id_ex_alu_decode: RTL and testbench

- Registered decode stage that turns a 32-bit RV32I instruction into the control bundle the execute-stage ALU consumes: operation, operand select, immediate, shift amount and destination info.
- Sits between fetch/ID and EX as the ID/EX pipeline register for ALU-class instructions.
- Uses a valid/ready handshake with flush.
- Produces alu_op as alu_op_pkg::alu_op_t: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU.

---
 rtl/id_ex_alu_decode.sv | 204 ++++++++++++++++++++
 tb/tb_id_ex_alu_decode.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_decode.sv
// ID/EX pipeline register for RV32I ALU-class instructions: decodes instr into the
// execute-stage ALU control bundle and holds it behind a valid/ready handshake with flush.
package alu_op_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic        src2_imm;
    logic [31:0] imm;
    logic [4:0]  shamt_imm;
    logic        shamt_use_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic [2:0]  branch_f3;
    logic        illegal;
  } dec_t;
endpackage

module id_ex_alu_decode
  import alu_op_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output alu_op_t         alu_op,
  output logic            src2_imm,
  output logic [XLEN-1:0] imm_out,
  output logic [4:0]      shamt_imm,
  output logic            shamt_use_reg,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            is_branch,
  output logic [2:0]      branch_f3,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_ok;
  logic       w_capture;
  dec_t       w_dec;

  dec_t            r_dec;
  logic [XLEN-1:0] r_pc;
  logic            r_out_valid;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];

  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    w_ok      = 1'b1;
    w_dec     = '0;
    w_dec.alu_op = ALU_ADD;
    w_dec.rs1 = instr[19:15];
    w_dec.rs2 = instr[24:20];
    w_dec.rd  = instr[11:7];
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_ZERO) begin
          case (w_f3)
            3'b000:  w_dec.alu_op = ALU_ADD;
            3'b001:  w_dec.alu_op = ALU_SLL;
            3'b010:  w_dec.alu_op = ALU_SLT;
            3'b011:  w_dec.alu_op = ALU_SLTU;
            3'b100:  w_dec.alu_op = ALU_XOR;
            3'b101:  w_dec.alu_op = ALU_SRL;
            3'b110:  w_dec.alu_op = ALU_OR;
            default: w_dec.alu_op = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_dec.alu_op = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_dec.alu_op = ALU_SRA;
        end else begin
          w_ok = 1'b0;
        end
        w_dec.shamt_use_reg = (w_f3 == 3'b001) || (w_f3 == 3'b101);
        w_dec.reg_write     = (instr[11:7] != 5'd0);
      end
      OPC_OP_IMM: begin
        w_dec.src2_imm  = 1'b1;
        w_dec.imm       = {{20{instr[31]}}, instr[31:20]};
        w_dec.shamt_imm = instr[24:20];
        w_dec.reg_write = (instr[11:7] != 5'd0);
        case (w_f3)
          3'b000:  w_dec.alu_op = ALU_ADD;
          3'b010:  w_dec.alu_op = ALU_SLT;
          3'b011:  w_dec.alu_op = ALU_SLTU;
          3'b100:  w_dec.alu_op = ALU_XOR;
          3'b110:  w_dec.alu_op = ALU_OR;
          3'b111:  w_dec.alu_op = ALU_AND;
          3'b001: begin
            w_dec.alu_op = ALU_SLL;
            w_ok         = (w_f7 == F7_ZERO);
          end
          default: begin
            w_dec.alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_ok         = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          end
        endcase
      end
      OPC_BRANCH: begin
        w_dec.is_branch = 1'b1;
        w_dec.branch_f3 = w_f3;
        w_dec.imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (w_f3)
          3'b000, 3'b001: w_dec.alu_op = ALU_SUB;
          3'b100, 3'b101: w_dec.alu_op = ALU_SLT;
          3'b110, 3'b111: w_dec.alu_op = ALU_SLTU;
          default:        w_ok = 1'b0;
        endcase
      end
      default: begin
        w_ok      = 1'b0;
        w_dec.rs1 = 5'd0;
        w_dec.rs2 = 5'd0;
        w_dec.rd  = 5'd0;
      end
    endcase
    // Illegal entries keep their register indices but carry no side effects.
    if (!w_ok) begin
      w_dec.alu_op        = ALU_ADD;
      w_dec.src2_imm      = 1'b0;
      w_dec.imm           = '0;
      w_dec.shamt_imm     = '0;
      w_dec.shamt_use_reg = 1'b0;
      w_dec.reg_write     = 1'b0;
      w_dec.is_branch     = 1'b0;
      w_dec.branch_f3     = '0;
      w_dec.illegal       = 1'b1;
    end
  end

  assign in_ready  = !r_out_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_pc         <= '0;
      r_dec        <= '0;
      r_dec.alu_op <= ALU_ADD;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_dec       <= w_dec;
      r_pc        <= pc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_op        = r_dec.alu_op;
  assign src2_imm      = r_dec.src2_imm;
  assign imm_out       = r_dec.imm;
  assign shamt_imm     = r_dec.shamt_imm;
  assign shamt_use_reg = r_dec.shamt_use_reg;
  assign rs1           = r_dec.rs1;
  assign rs2           = r_dec.rs2;
  assign rd            = r_dec.rd;
  assign reg_write     = r_dec.reg_write;
  assign is_branch     = r_dec.is_branch;
  assign branch_f3     = r_dec.branch_f3;
  assign illegal       = r_dec.illegal;
  assign pc_out        = r_pc;

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Directed bench for id_ex_alu_decode: hand-decoded RV32I vectors, handshake,
// backpressure, flush priority and asynchronous reset.
module tb_id_ex_alu_decode;
  import alu_op_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  alu_op_t     alu_op;
  logic        src2_imm;
  logic [31:0] imm_out;
  logic [4:0]  shamt_imm;
  logic        shamt_use_reg;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        is_branch;
  logic [2:0]  branch_f3;
  logic        illegal;
  logic [31:0] pc_out;

  int n_vec;
  int n_miss;

  id_ex_alu_decode #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .src2_imm(src2_imm),
    .imm_out(imm_out), .shamt_imm(shamt_imm), .shamt_use_reg(shamt_use_reg),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .is_branch(is_branch), .branch_f3(branch_f3), .illegal(illegal),
    .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction with out_ready=1 and sample 1 ns after the capturing edge.
  task automatic send(input logic [31:0] i_instr, input logic [31:0] i_pc);
    @(negedge clk);
    instr     = i_instr;
    pc        = i_pc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("out_valid_after_send", {31'd0, out_valid}, 32'd1);
    check("pc_out", pc_out, i_pc);
  endtask

  task automatic expect_dec(input string tag, input alu_op_t e_op, input logic e_src2,
                            input logic [31:0] e_imm, input logic [4:0] e_shamt,
                            input logic e_use_reg, input logic [4:0] e_rs1,
                            input logic [4:0] e_rs2, input logic [4:0] e_rd,
                            input logic e_wr, input logic e_br, input logic [2:0] e_f3,
                            input logic e_ill);
    check({tag, ".alu_op"},        {28'd0, alu_op},        {28'd0, e_op});
    check({tag, ".src2_imm"},      {31'd0, src2_imm},      {31'd0, e_src2});
    check({tag, ".imm_out"},       imm_out,                e_imm);
    check({tag, ".shamt_imm"},     {27'd0, shamt_imm},     {27'd0, e_shamt});
    check({tag, ".shamt_use_reg"}, {31'd0, shamt_use_reg}, {31'd0, e_use_reg});
    check({tag, ".rs1"},           {27'd0, rs1},           {27'd0, e_rs1});
    check({tag, ".rs2"},           {27'd0, rs2},           {27'd0, e_rs2});
    check({tag, ".rd"},            {27'd0, rd},            {27'd0, e_rd});
    check({tag, ".reg_write"},     {31'd0, reg_write},     {31'd0, e_wr});
    check({tag, ".is_branch"},     {31'd0, is_branch},     {31'd0, e_br});
    check({tag, ".branch_f3"},     {29'd0, branch_f3},     {29'd0, e_f3});
    check({tag, ".illegal"},       {31'd0, illegal},       {31'd0, e_ill});
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'd0;
    pc        = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    expect_dec("reset", ALU_ADD, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
               1'b0, 1'b0, 3'd0, 1'b0);
    check("reset.pc_out", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // sub a0,a0,a1
    send(32'h40B5_0533, 32'h0000_1000);
    expect_dec("sub", ALU_SUB, 1'b0, 32'd0, 5'd0, 1'b0, 5'd10, 5'd11, 5'd10,
               1'b1, 1'b0, 3'd0, 1'b0);
    // addi x1,x0,-1
    send(32'hFFF0_0093, 32'h0000_1004);
    expect_dec("addi", ALU_ADD, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 5'd0, 5'd31, 5'd1,
               1'b1, 1'b0, 3'd0, 1'b0);
    // srai x2,x1,3
    send(32'h4030_D113, 32'h0000_1008);
    expect_dec("srai", ALU_SRA, 1'b1, 32'h0000_0403, 5'd3, 1'b0, 5'd1, 5'd3, 5'd2,
               1'b1, 1'b0, 3'd0, 1'b0);
    // srl a0,a0,a1 uses the register shift amount
    send(32'h00B5_5533, 32'h0000_100C);
    expect_dec("srl", ALU_SRL, 1'b0, 32'd0, 5'd0, 1'b1, 5'd10, 5'd11, 5'd10,
               1'b1, 1'b0, 3'd0, 1'b0);
    // blt x1,x2,-4
    send(32'hFE20_CEE3, 32'h0000_1010);
    expect_dec("blt", ALU_SLT, 1'b0, 32'hFFFF_FFFC, 5'd0, 1'b0, 5'd1, 5'd2, 5'd29,
               1'b0, 1'b1, 3'd4, 1'b0);
    // slt x0,x1,x0: legal, but rd=0 suppresses the write
    send(32'h0000_A033, 32'h0000_1014);
    expect_dec("slt_rd0", ALU_SLT, 1'b0, 32'd0, 5'd0, 1'b0, 5'd1, 5'd0, 5'd0,
               1'b0, 1'b0, 3'd0, 1'b0);
    // OP with funct7=0000001
    send(32'h0200_A033, 32'h0000_1018);
    expect_dec("op_f7_bad", ALU_ADD, 1'b0, 32'd0, 5'd0, 1'b0, 5'd1, 5'd0, 5'd0,
               1'b0, 1'b0, 3'd0, 1'b1);
    // slli with funct7=0100000
    send(32'h4020_9093, 32'h0000_101C);
    expect_dec("slli_bad", ALU_ADD, 1'b0, 32'd0, 5'd0, 1'b0, 5'd1, 5'd2, 5'd1,
               1'b0, 1'b0, 3'd0, 1'b1);
    // branch funct3=010
    send(32'h0000_2063, 32'h0000_1020);
    expect_dec("br_f3_bad", ALU_ADD, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
               1'b0, 1'b0, 3'd0, 1'b1);
    // unknown opcode: register indices forced to zero
    send(32'hFFFF_FFFF, 32'h0000_1024);
    expect_dec("bad_opc", ALU_ADD, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
               1'b0, 1'b0, 3'd0, 1'b1);

    // Release without capture: out_valid drops, data holds
    @(posedge clk);
    #1;
    check("release.out_valid", {31'd0, out_valid}, 32'd0);
    check("release.pc_hold", pc_out, 32'h0000_1024);

    // Backpressure: hold sub for 3 cycles while a new instruction waits
    send(32'h40B5_0533, 32'h0000_2000);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF0_0093;
    pc        = 32'h0000_2004;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold.in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("hold.out_valid", {31'd0, out_valid}, 32'd1);
      check("hold.alu_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
      check("hold.pc_out", pc_out, 32'h0000_2000);
      check("hold.src2_imm", {31'd0, src2_imm}, 32'd0);
      @(negedge clk);
    end

    // Flush beats a simultaneous capture
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("flush.out_valid", {31'd0, out_valid}, 32'd0);
    check("flush.pc_not_taken", pc_out, 32'h0000_2000);
    check("flush.alu_not_taken", {28'd0, alu_op}, {28'd0, ALU_SUB});
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Asynchronous reset while an entry is held
    send(32'h4030_D113, 32'h0000_3000);
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    check("prerst.out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst.alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    check("async_rst.shamt_imm", {27'd0, shamt_imm}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;

    // Capture still works after reset
    send(32'h0000_A033, 32'h0000_4000);
    check("post_rst.alu_op", {28'd0, alu_op}, {28'd0, ALU_SLT});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
